// File: rtl/tx_pkg.sv
// Shared encodings and default timing constants for the OFDM frame scheduler.
// The legality helper is shared so the top and any future checker agree on it.
package tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_BOF  = 2'd2
   } state_e;

   localparam logic [1:0] SEL_ZERO = 2'd0;
   localparam logic [1:0] SEL_HDR  = 2'd1;
   localparam logic [1:0] SEL_DATA = 2'd2;

   localparam int PHASES  = 64;
   localparam int FFTLAT  = 22;
   localparam int HDR_CYC = 320 / PHASES;
   localparam int GRP_SYM = 4;
   localparam int GRP_CYC = 5;
   localparam int MAXSYM  = 48;
   localparam int BOFF    = 4;

   // A frame must hold at least one whole symbol group and fit the frame budget.
   function automatic logic nsym_legal(input logic [5:0] n, input logic [5:0] maxsym);
      return (n != 6'd0) && ((n % 6'(GRP_SYM)) == 6'd0) && (n <= maxsym);
   endfunction

endpackage

// File: rtl/tx_lat_pipe.sv
// Fixed-depth 1-bit delay line modelling the FFT valid latency.
module tx_lat_pipe #(
   parameter int DEPTH = 22
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic din,
   output logic dout
);

   logic [DEPTH-1:0] stages;

   // Shift register; reset clears every stage so no stale valids survive.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         stages <= {DEPTH{1'b0}};
      end else begin
         stages <= {stages[DEPTH-2:0], din};
      end
   end

   assign dout = stages[DEPTH-1];

endmodule

// File: rtl/tx_frame_sched.sv
// Frame scheduler: sequences data launches, STF header and CP-gearbox phase
// so header and data leave back-to-back, tracking FFT latency explicitly.
module tx_frame_sched #(
   parameter int PHASES  = tx_pkg::PHASES,
   parameter int FFTLAT  = tx_pkg::FFTLAT,
   parameter int HDR_CYC = 320 / PHASES,
   parameter int MAXSYM  = tx_pkg::MAXSYM,
   parameter int BOFF    = tx_pkg::BOFF
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   input  logic [5:0] nsym_i,
   output logic       start_ack_o,
   output logic       busy_o,
   output logic       src_en_o,
   output logic       hdr_en_o,
   input  logic       fft_valid_i,
   output logic       buf_wr_o,
   output logic [1:0] out_sel_o,
   output logic [2:0] cp_phase_o,
   output logic       out_valid_o,
   output logic       done_o,
   output logic       err_o
);

   import tx_pkg::*;

   localparam logic [7:0] HDR_LO   = 8'(FFTLAT - HDR_CYC + 1);
   localparam logic [7:0] HDR_HI   = 8'(FFTLAT);
   localparam logic [7:0] DAT_LO   = 8'(FFTLAT + 1);
   localparam logic [3:0] BOFF_V   = 4'(BOFF);
   localparam logic [5:0] MAXSYM_V = 6'(MAXSYM);
   localparam logic [2:0] PH_LAST  = 3'(GRP_CYC - 1);

   state_e     state_r, state_n;
   logic [7:0] t_r, t_n;
   logic [7:0] lim_r, lim_n;
   logic [7:0] send_r, send_n;
   logic [3:0] bof_r, bof_n;
   logic [2:0] ph_r, ph_n;
   logic [2:0] cp_n;
   logic [1:0] sel_n;
   logic       err_n, ack_n, src_n, hdr_n, dat_n, done_n, busy_n;
   logic       exp_v;

   tx_lat_pipe #(.DEPTH(FFTLAT)) u_lat_pipe (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .din    (src_en_o),
      .dout   (exp_v)
   );

   assign buf_wr_o = exp_v & fft_valid_i;

   // Next-state logic: frame counter, group phase, backoff and error tracking.
   always_comb begin
      state_n = state_r;
      t_n     = t_r;
      lim_n   = lim_r;
      send_n  = send_r;
      bof_n   = bof_r;
      ph_n    = ph_r;
      err_n   = err_o;
      ack_n   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            t_n   = 8'd0;
            ph_n  = 3'd0;
            bof_n = 4'd0;
            if (start_i) begin
               ack_n = 1'b1;
               if (nsym_legal(nsym_i, MAXSYM_V)) begin
                  state_n = ST_RUN;
                  t_n     = 8'd1;
                  send_n  = 8'(nsym_i / 6'(GRP_SYM)) * 8'(GRP_CYC);
                  lim_n   = 8'(FFTLAT) + 8'(nsym_i / 6'(GRP_SYM)) * 8'(GRP_CYC);
               end else begin
                  err_n = 1'b1;
               end
            end else begin
               ack_n = 1'b0;
            end
         end
         ST_RUN: begin
            if (exp_v != fft_valid_i) begin
               err_n = 1'b1;
            end else begin
               err_n = err_o;
            end
            if (t_r == lim_r) begin
               state_n = ST_BOF;
               bof_n   = 4'd1;
            end else begin
               t_n  = t_r + 8'd1;
               ph_n = (ph_r == PH_LAST) ? 3'd0 : ph_r + 3'd1;
            end
         end
         ST_BOF: begin
            if (bof_r == BOFF_V) begin
               state_n = ST_IDLE;
               t_n     = 8'd0;
               bof_n   = 4'd0;
            end else begin
               bof_n = bof_r + 4'd1;
            end
         end
         default: begin
            state_n = ST_IDLE;
            t_n     = 8'd0;
            bof_n   = 4'd0;
         end
      endcase
   end

   // Output decode from the next-cycle counters so every output is a flop.
   always_comb begin
      src_n  = (state_n == ST_RUN) && (t_n <= send_n) && (ph_n != PH_LAST);
      hdr_n  = (state_n == ST_RUN) && (t_n >= HDR_LO) && (t_n <= HDR_HI);
      dat_n  = (state_n == ST_RUN) && (t_n >= DAT_LO);
      done_n = (state_n == ST_BOF) && (bof_n == BOFF_V);
      busy_n = (state_n != ST_IDLE);
      cp_n   = 3'd0;
      sel_n  = SEL_ZERO;
      if (dat_n) begin
         sel_n = SEL_DATA;
         if (t_n == DAT_LO) begin
            cp_n = 3'd0;
         end else begin
            cp_n = (cp_phase_o == PH_LAST) ? 3'd0 : cp_phase_o + 3'd1;
         end
      end else if (hdr_n) begin
         sel_n = SEL_HDR;
      end else begin
         sel_n = SEL_ZERO;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_r     <= ST_IDLE;
         t_r         <= 8'd0;
         lim_r       <= 8'd0;
         send_r      <= 8'd0;
         bof_r       <= 4'd0;
         ph_r        <= 3'd0;
         start_ack_o <= 1'b0;
         busy_o      <= 1'b0;
         src_en_o    <= 1'b0;
         hdr_en_o    <= 1'b0;
         out_sel_o   <= SEL_ZERO;
         cp_phase_o  <= 3'd0;
         out_valid_o <= 1'b0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         state_r     <= state_n;
         t_r         <= t_n;
         lim_r       <= lim_n;
         send_r      <= send_n;
         bof_r       <= bof_n;
         ph_r        <= ph_n;
         start_ack_o <= ack_n;
         busy_o      <= busy_n;
         src_en_o    <= src_n;
         hdr_en_o    <= hdr_n;
         out_sel_o   <= sel_n;
         cp_phase_o  <= cp_n;
         out_valid_o <= hdr_n | dat_n;
         done_o      <= done_n;
         err_o       <= err_n;
      end
   end

endmodule
